monitor_tx_framer: RTL and testbench

MONITOR_TX_FRAMER -- requirements
Module: monitor_tx_framer

---
 rtl/monitor_tx_framer.sv | 120 ++++++++++++
 tb/tb_monitor_tx_framer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/monitor_tx_framer.sv
// Snapshots LED and seven-segment state and streams it as a framed byte sequence
// over a valid/ready link. Define MONITOR_TX_CHECKSUM_EN to append an XOR checksum byte.
module monitor_tx_framer #(
    parameter int clock   = 50000000,
    parameter int refresh = 10
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [9:0] i_LEDS,
    input  logic [6:0] i_7S5,
    input  logic [6:0] i_7S4,
    input  logic [6:0] i_7S3,
    input  logic [6:0] i_7S2,
    input  logic [6:0] i_7S1,
    input  logic [6:0] i_7S0,
    output logic [7:0] o_DATA,
    output logic       o_VALID,
    input  logic       i_READY,
    output logic       o_BUSY
);

    localparam int P  = clock / refresh;
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] CNT_MAX = CW'(P - 1);

`ifdef MONITOR_TX_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // seg[5] is digit 7S5, seg[0] is digit 7S0
    typedef struct packed {
        logic [9:0]      leds;
        logic [5:0][6:0] seg;
    } snap_t;

    snap_t         cur;
    snap_t         snap;
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic          frc;
    logic          start;
    logic          xfer;
    logic [7:0]    byte_mux;

    assign cur   = {i_LEDS, i_7S5, i_7S4, i_7S3, i_7S2, i_7S1, i_7S0};
    assign start = (state == IDLE) && ((cur != snap) || (cnt == CNT_MAX) || frc);
    assign xfer  = (state == SEND) && i_READY;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= IDLE;
            snap  <= '0;
            cnt   <= '0;
            idx   <= '0;
            frc   <= 1'b1;
        end else if (state == IDLE) begin
            if (start) begin
                state <= SEND;
                snap  <= cur;
                cnt   <= '0;
                idx   <= '0;
                frc   <= 1'b0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
            if (xfer) begin
                if (idx == LAST_IDX) begin
                    state <= IDLE;
                    idx   <= '0;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

`ifdef MONITOR_TX_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = {6'b0, snap.leds[9:8]} ^ snap.leds[7:0];
        for (int i = 0; i < 6; i++) begin
            csum = csum ^ {1'b0, snap.seg[i]};
        end
    end
`endif

    always_comb begin
        byte_mux = 8'h00;
        case (idx)
            4'd0: byte_mux = 8'hA5;
            4'd1: byte_mux = {6'b0, snap.leds[9:8]};
            4'd2: byte_mux = snap.leds[7:0];
            4'd3: byte_mux = {1'b0, snap.seg[5]};
            4'd4: byte_mux = {1'b0, snap.seg[4]};
            4'd5: byte_mux = {1'b0, snap.seg[3]};
            4'd6: byte_mux = {1'b0, snap.seg[2]};
            4'd7: byte_mux = {1'b0, snap.seg[1]};
            4'd8: byte_mux = {1'b0, snap.seg[0]};
`ifdef MONITOR_TX_CHECKSUM_EN
            4'd9: byte_mux = csum;
`endif
            default: byte_mux = 8'h00;
        endcase
    end

    // Outputs decode straight from state so reset and frame end force 0x00 at once
    assign o_VALID = (state == SEND);
    assign o_BUSY  = (state == SEND);
    assign o_DATA  = (state == SEND) ? byte_mux : 8'h00;

endmodule

// File: tb/tb_monitor_tx_framer.sv
// Scoreboard bench for monitor_tx_framer: expected frame bytes are queued when
// stimulus is applied and popped on every valid/ready transfer.
module tb_monitor_tx_framer;

`ifdef MONITOR_TX_CHECKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic       i_CLK;
    logic       i_RST;
    logic [9:0] i_LEDS;
    logic [6:0] seg [6];
    logic [7:0] o_DATA;
    logic       o_VALID;
    logic       i_READY;
    logic       o_BUSY;

    int checks = 0;
    int fails  = 0;
    int n_xfer = 0;
    logic [7:0] q [$];

    monitor_tx_framer #(.clock(1000), .refresh(10)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_LEDS(i_LEDS),
        .i_7S5(seg[5]), .i_7S4(seg[4]), .i_7S3(seg[3]),
        .i_7S2(seg[2]), .i_7S1(seg[1]), .i_7S0(seg[0]),
        .o_DATA(o_DATA), .o_VALID(o_VALID), .i_READY(i_READY), .o_BUSY(o_BUSY)
    );

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic wait_level(input logic lvl, input int bound, output int n);
        n = 0;
        while (o_VALID !== lvl && n < bound) begin
            tick();
            n++;
        end
    endtask

    // Independent frame model built from the inputs currently driven
    task automatic push_frame();
        logic [7:0] b [1:8];
        logic [7:0] cs;
        b[1] = {6'b0, i_LEDS[9:8]};
        b[2] = i_LEDS[7:0];
        for (int i = 0; i < 6; i++) b[3+i] = {1'b0, seg[5-i]};
        cs = 8'h00;
        q.push_back(8'hA5);
        for (int i = 1; i <= 8; i++) begin
            q.push_back(b[i]);
            cs = cs ^ b[i];
        end
        if (NB == 10) q.push_back(cs);
    endtask

    // Transfer monitor plus stall-stability check, sampled mid-cycle
    initial begin
        logic       held_v;
        logic [7:0] held_d;
        held_v = 1'b0;
        held_d = 8'h00;
        forever begin
            @(negedge i_CLK);
            if (held_v && o_VALID && !i_RST) chk("hold", o_DATA, held_d);
            if (o_VALID === 1'b1 && i_READY && !i_RST) begin
                n_xfer++;
                chk("sb_pending", q.size() != 0, 1);
                if (q.size() != 0) chk("xfer_data", o_DATA, q.pop_front());
            end
            held_v = o_VALID && !i_READY && !i_RST;
            held_d = o_DATA;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int x0;
        i_RST   = 1'b1;
        i_LEDS  = 10'h000;
        i_READY = 1'b1;
        for (int i = 0; i < 6; i++) seg[i] = 7'h7F;
        repeat (3) tick();
        chk("rst_valid", o_VALID, 0);
        chk("rst_data", o_DATA, 8'h00);
        chk("rst_busy", o_BUSY, 0);

        // Forced frame right after reset release
        q.push_back(8'hA5); q.push_back(8'h00); q.push_back(8'h00);
        repeat (6) q.push_back(8'h7F);
        if (NB == 10) q.push_back(8'h00);
        i_RST = 1'b0;
        tick();
        chk("rel_valid", o_VALID, 1);
        chk("rel_busy", o_BUSY, 1);
        chk("rel_hdr", o_DATA, 8'hA5);
        wait_level(1'b0, 50, n);
        chk("rel_len", n, NB);
        chk("end_data", o_DATA, 8'h00);

        // Constant inputs: periodic refresh
        push_frame();
        wait_level(1'b1, 300, n);
        chk("refresh_gap", n, 100);
        chk("refresh_hdr", o_DATA, 8'hA5);
        wait_level(1'b0, 50, n);
        chk("refresh_len", n, NB);

        // Input change in IDLE
        i_LEDS = 10'h3A5;
        for (int i = 0; i < 6; i++) seg[i] = 7'h00;
        seg[0] = 7'h06;
        q.push_back(8'hA5); q.push_back(8'h03); q.push_back(8'hA5);
        repeat (5) q.push_back(8'h00);
        q.push_back(8'h06);
        if (NB == 10) q.push_back(8'hA0);
        tick();
        chk("chg_valid", o_VALID, 1);
        chk("chg_hdr", o_DATA, 8'hA5);
        wait_level(1'b0, 50, n);
        chk("chg_len", n, NB);

        // Toggling ready with inputs changing every cycle
        x0 = n_xfer;
        i_LEDS = 10'h155;
        push_frame();
        tick();
        chk("tog_hdr", o_DATA, 8'hA5);
        n = 0;
        while (o_VALID && n < 100) begin
            i_READY = ~i_READY;
            i_LEDS  = i_LEDS + 10'd7;
            tick();
            n++;
        end
        chk("tog_end", o_VALID, 0);
        push_frame();
        i_READY = 1'b1;
        tick();
        chk("tog_xfers", n_xfer - x0, NB);
        chk("gap_valid", o_VALID, 1);
        chk("gap_hdr", o_DATA, 8'hA5);
        wait_level(1'b0, 50, n);
        chk("gap_len", n, NB);

        // Reset during byte 4 aborts the frame
        i_LEDS = 10'h2C3;
        seg[4] = 7'h55;
        push_frame();
        tick();
        chk("abort_hdr", o_DATA, 8'hA5);
        repeat (4) tick();
        chk("abort_b4", o_DATA, 8'h55);
        i_RST = 1'b1;
        q.delete();
        tick();
        chk("abort_valid", o_VALID, 0);
        chk("abort_data", o_DATA, 8'h00);
        chk("abort_busy", o_BUSY, 0);
        tick();
        chk("abort_hold", o_VALID, 0);
        push_frame();
        i_RST = 1'b0;
        tick();
        chk("resume_valid", o_VALID, 1);
        chk("resume_hdr", o_DATA, 8'hA5);
        wait_level(1'b0, 50, n);
        chk("resume_len", n, NB);

        tick();
        chk("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
